// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_stage_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;
    typedef logic [3:0]  MemOpBus;

    localparam RegBus ZeroWord     = 32'h0000_0000;
    localparam logic  WriteDisable = 1'b0;

    localparam MemOpBus MEM_NOP = 4'd0;
    localparam MemOpBus MEM_LB  = 4'd1;
    localparam MemOpBus MEM_LH  = 4'd2;
    localparam MemOpBus MEM_LW  = 4'd3;
    localparam MemOpBus MEM_LBU = 4'd4;
    localparam MemOpBus MEM_LHU = 4'd5;
    localparam MemOpBus MEM_SB  = 4'd6;
    localparam MemOpBus MEM_SH  = 4'd7;
    localparam MemOpBus MEM_SW  = 4'd8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBeat0 = 2'd1,
        StBeat1 = 2'd2,
        StDone  = 2'd3
    } mem_state_e;

    // Access size in bytes; 0 for anything that is not a load or store.
    function automatic logic [2:0] mem_size(input MemOpBus op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: mem_size = 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: mem_size = 3'd2;
            MEM_LW, MEM_SW:          mem_size = 3'd4;
            default:                 mem_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane alignment: byte mask, split detect, store shift, load extract/extend.
module mem_stage_align
    import mem_stage_pkg::*;
(
    input  MemOpBus     op_i,
    input  logic [1:0]  off_i,
    input  RegBus       sdata_i,
    input  logic [63:0] rdata64_i,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic [7:0]  mask8_o,
    output logic        split_o,
    output logic [63:0] sdata64_o,
    output RegBus       ldata_o
);

    logic [2:0] size;
    logic [7:0] base_mask;
    RegBus      raw;

    // Decode op, build masks and shift data into/out of byte lanes.
    always_comb begin
        size       = mem_size(op_i);
        is_load_o  = (op_i >= MEM_LB) && (op_i <= MEM_LHU);
        is_store_o = (op_i >= MEM_SB) && (op_i <= MEM_SW);

        case (size)
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            3'd4:    base_mask = 8'h0F;
            default: base_mask = 8'h00;
        endcase
        mask8_o = base_mask << off_i;
        split_o = (3'({1'b0, off_i}) + size) > 3'd4;

        sdata64_o = {32'h0, sdata_i} << {off_i, 3'b000};
        raw       = 32'(rdata64_i >> {off_i, 3'b000});

        case (op_i)
            MEM_LB:  ldata_o = {{24{raw[7]}}, raw[7:0]};
            MEM_LH:  ldata_o = {{16{raw[15]}}, raw[15:0]};
            MEM_LW:  ldata_o = raw;
            MEM_LBU: ldata_o = {24'h0, raw[7:0]};
            MEM_LHU: ldata_o = {16'h0, raw[15:0]};
            default: ldata_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one or two aligned beats per load/store and stalls upstream.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_enable_i,
    input  RegAddrBus         w_addr_i,
    input  RegBus             w_data_i,
    input  MemOpBus           mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  RegBus             mem_sdata_i,
    output logic              w_enable_o,
    output RegAddrBus         w_addr_o,
    output RegBus             w_data_o,
    output logic              stall_req_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output RegBus             mem_wdata_o,
    input  logic              mem_ready_i,
    input  RegBus             mem_rdata_i
);

    mem_state_e        state_q;
    RegBus             beat0_q;
    RegBus             beat1_q;

    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              split;
    logic [7:0]        mask8;
    logic [63:0]       sdata64;
    RegBus             load_data;
    logic              wb_nz;
    logic [ADDR_W-1:0] beat0_addr;
    logic [ADDR_W-1:0] beat1_addr;

    mem_stage_align u_align (
        .op_i       (mem_op_i),
        .off_i      (mem_addr_i[1:0]),
        .sdata_i    (mem_sdata_i),
        .rdata64_i  ({beat1_q, beat0_q}),
        .is_load_o  (is_load),
        .is_store_o (is_store),
        .mask8_o    (mask8),
        .split_o    (split),
        .sdata64_o  (sdata64),
        .ldata_o    (load_data)
    );

    assign is_mem     = is_load || is_store;
    assign wb_nz      = (w_addr_i != '0);
    assign beat0_addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
    assign beat1_addr = beat0_addr + ADDR_W'(4);

    // Beat sequencing; read data is captured on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat0_q <= ZeroWord;
            beat1_q <= ZeroWord;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_mem) state_q <= StBeat0;
                end
                StBeat0: begin
                    if (mem_ready_i) begin
                        beat0_q <= mem_rdata_i;
                        state_q <= split ? StBeat1 : StDone;
                    end
                end
                StBeat1: begin
                    if (mem_ready_i) begin
                        beat1_q <= mem_rdata_i;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs; inputs are held by the stall, so bus fields stay stable while a beat waits.
    always_comb begin
        w_enable_o  = WriteDisable;
        w_addr_o    = '0;
        w_data_o    = ZeroWord;
        stall_req_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'h0;
        mem_wdata_o = ZeroWord;
        if (!rst) begin
            w_addr_o = w_addr_i;
            case (state_q)
                StIdle: begin
                    if (is_mem) begin
                        stall_req_o = 1'b1;
                    end else begin
                        w_enable_o = w_enable_i && wb_nz;
                        w_data_o   = wb_nz ? w_data_i : ZeroWord;
                    end
                end
                StBeat0: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = is_store;
                    mem_addr_o  = beat0_addr;
                    mem_be_o    = mask8[3:0];
                    mem_wdata_o = sdata64[31:0];
                end
                StBeat1: begin
                    stall_req_o = 1'b1;
                    mem_req_o   = 1'b1;
                    mem_we_o    = is_store;
                    mem_addr_o  = beat1_addr;
                    mem_be_o    = mask8[7:4];
                    mem_wdata_o = sdata64[63:32];
                end
                StDone: begin
                    if (is_load) begin
                        w_enable_o = w_enable_i && wb_nz;
                        w_data_o   = wb_nz ? load_data : ZeroWord;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand sequences, randomized ops vs byte model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_enable_i;
    logic [4:0]  w_addr_i;
    logic [31:0] w_data_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        w_enable_o;
    logic [4:0]  w_addr_o;
    logic [31:0] w_data_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rdata_i;

    mem_stage #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .w_enable_i  (w_enable_i),
        .w_addr_i    (w_addr_i),
        .w_data_i    (w_data_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_sdata_i (mem_sdata_i),
        .w_enable_o  (w_enable_o),
        .w_addr_o    (w_addr_o),
        .w_data_o    (w_data_o),
        .stall_req_o (stall_req_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Word memory seen by the DUT, and an independent byte-level reference memory.
    logic [31:0] mem [1024];
    logic [7:0]  ref_mem [4096];
    assign mem_rdata_i = mem[mem_addr_o[11:2]];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;
    beat_t log_q[$];

    int fixed_wait  = 0;
    int wait_target = 0;
    int wait_cnt    = 0;

    logic        hold_pending = 1'b0;
    logic        snap_we;
    logic [31:0] snap_addr;
    logic [3:0]  snap_be;
    logic [31:0] snap_wdata;

    function automatic int pick_wait();
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Memory responder: logs accepted beats, applies writes, checks held requests, drives ready.
    always @(posedge clk) begin
        if (!rst && hold_pending) begin
            checks++;
            if (!(mem_req_o && mem_we_o == snap_we && mem_addr_o == snap_addr &&
                  mem_be_o == snap_be && mem_wdata_o == snap_wdata)) begin
                errors++;
                $display("FAIL hold_stable got req=%b addr=%h be=%h wd=%h want addr=%h be=%h wd=%h",
                         mem_req_o, mem_addr_o, mem_be_o, mem_wdata_o,
                         snap_addr, snap_be, snap_wdata);
            end
        end
        hold_pending = !rst && mem_req_o && !mem_ready_i;
        snap_we    = mem_we_o;
        snap_addr  = mem_addr_o;
        snap_be    = mem_be_o;
        snap_wdata = mem_wdata_o;
        if (!rst && mem_req_o && mem_ready_i) begin
            log_q.push_back(beat_t'{mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o});
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
            end
            wait_cnt    = 0;
            wait_target = pick_wait();
        end
        #1;
        if (mem_req_o) begin
            if (wait_cnt >= wait_target) begin
                mem_ready_i = 1'b1;
            end else begin
                mem_ready_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready_i = 1'b0;
            wait_cnt    = 0;
            wait_target = pick_wait();
        end
    end

    // Reference model: little-endian byte memory.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < op_size(op); i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
        case (op)
            MEM_LB:  return {{24{v[7]}}, v[7:0]};
            MEM_LH:  return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    task automatic model_store(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] sd);
        for (int i = 0; i < op_size(op); i++) ref_mem[int'(addr) + i] = sd[8*i +: 8];
    endtask

    task automatic poke(input int byte_addr, input logic [31:0] val);
        mem[byte_addr / 4] = val;
        for (int b = 0; b < 4; b++) ref_mem[byte_addr + b] = val[8*b +: 8];
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        int          stalls;
        int          beats;
        logic        early_we;
    } res_t;

    // Apply one instruction and run until the stall drops; the result is sampled in that cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] wd, input logic [4:0] wa, input logic we,
                          output res_t r);
        @(negedge clk);
        log_q.delete();
        mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sd;
        w_data_i = wd; w_addr_i = wa; w_enable_i = we;
        r.stalls = 0;
        r.early_we = 1'b0;
        #1;
        while (stall_req_o && r.stalls < 100) begin
            r.stalls++;
            if (w_enable_o) r.early_we = 1'b1;
            @(negedge clk);
            #1;
        end
        if (stall_req_o) begin
            errors++;
            $display("FAIL stall_timeout got stall=1 want stall=0 within 100 cycles");
        end
        r.we    = w_enable_o;
        r.waddr = w_addr_o;
        r.data  = w_data_o;
        r.beats = log_q.size();
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic        wen;
        logic        exp_we;
        logic [31:0] exp_wd;
        int          exp_stalls;
        int          exp_beats;
        logic [31:0] exp_addr0;
        logic [3:0]  exp_be0;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[12];
        res_t  r;
        int    k;
        int    bad_words;
        logic [3:0]  op;
        logic [31:0] addr, sd, wd, exp;
        logic [4:0]  wa;
        logic        we;
        int    nb, rv;

        vecs[0]  = '{MEM_NOP, 32'h0,   32'h1234,     5'd5, 1'b1, 1'b1, 32'h1234,     0, 0, 0, 0};
        vecs[1]  = '{MEM_NOP, 32'h0,   32'h1234,     5'd0, 1'b1, 1'b0, 32'h0,        0, 0, 0, 0};
        vecs[2]  = '{MEM_LW,  32'h100, 32'h0,        5'd3, 1'b1, 1'b1, 32'hDEADBEEF, 2, 1,
                     32'h100, 4'hF};
        vecs[3]  = '{MEM_LB,  32'h203, 32'h0,        5'd4, 1'b1, 1'b1, 32'hFFFFFF80, 2, 1,
                     32'h200, 4'h8};
        vecs[4]  = '{MEM_LBU, 32'h203, 32'h0,        5'd4, 1'b1, 1'b1, 32'h00000080, 2, 1,
                     32'h200, 4'h8};
        vecs[5]  = '{MEM_LH,  32'h102, 32'h0,        5'd6, 1'b1, 1'b1, 32'hFFFFDEAD, 2, 1,
                     32'h100, 4'hC};
        vecs[6]  = '{MEM_LHU, 32'h102, 32'h0,        5'd6, 1'b1, 1'b1, 32'h0000DEAD, 2, 1,
                     32'h100, 4'hC};
        vecs[7]  = '{MEM_LW,  32'h101, 32'h0,        5'd7, 1'b1, 1'b1, 32'h44DEADBE, 3, 2,
                     32'h100, 4'hE};
        vecs[8]  = '{MEM_LW,  32'h100, 32'h0,        5'd0, 1'b1, 1'b0, 32'h0,        2, 1,
                     32'h100, 4'hF};
        vecs[9]  = '{4'hF,    32'h100, 32'hCAFE0001, 5'd9, 1'b1, 1'b1, 32'hCAFE0001, 0, 0, 0, 0};
        vecs[10] = '{MEM_LW,  32'h100, 32'h0,        5'd3, 1'b0, 1'b0, 32'hDEADBEEF, 2, 1,
                     32'h100, 4'hF};
        vecs[11] = '{MEM_LH,  32'h103, 32'h0,        5'd2, 1'b1, 1'b1, 32'h000044DE, 3, 2,
                     32'h100, 4'h8};

        for (int w = 0; w < 1024; w++) poke(4 * w, $urandom);
        poke(32'h100, 32'hDEADBEEF);
        poke(32'h104, 32'h11223344);
        poke(32'h200, 32'h80000000);

        // Reset: every output low even with live-looking inputs.
        rst = 1'b1;
        mem_op_i = MEM_NOP; mem_addr_i = 32'h100; mem_sdata_i = 32'h0;
        w_enable_i = 1'b1; w_addr_i = 5'd5; w_data_i = 32'h1234;
        repeat (2) @(negedge clk);
        #1;
        check("rst_w_enable", 32'(w_enable_o), 32'h0);
        check("rst_w_data", w_data_o, 32'h0);
        check("rst_stall", 32'(stall_req_o), 32'h0);
        check("rst_mem_req", 32'(mem_req_o), 32'h0);
        check("rst_w_addr", 32'(w_addr_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        fixed_wait = 0;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].addr, 32'h0, vecs[i].wd, vecs[i].wa, vecs[i].wen, r);
            check($sformatf("vec%0d_we", i), 32'(r.we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_wd", i), r.data, vecs[i].exp_wd);
            check($sformatf("vec%0d_stalls", i), r.stalls, vecs[i].exp_stalls);
            check($sformatf("vec%0d_beats", i), r.beats, vecs[i].exp_beats);
            check($sformatf("vec%0d_early_we", i), 32'(r.early_we), 32'h0);
            if (vecs[i].exp_beats > 0 && log_q.size() > 0) begin
                check($sformatf("vec%0d_addr0", i), log_q[0].addr, vecs[i].exp_addr0);
                check($sformatf("vec%0d_be0", i), 32'(log_q[0].be), 32'(vecs[i].exp_be0));
                check($sformatf("vec%0d_we0", i), 32'(log_q[0].we), 32'h0);
            end
        end

        // Split store across 0x300/0x304.
        run_op(MEM_SW, 32'h302, 32'hAABBCCDD, 32'h0, 5'd0, 1'b0, r);
        model_store(MEM_SW, 32'h302, 32'hAABBCCDD);
        check("sw_beats", r.beats, 2);
        check("sw_w_enable", 32'(r.we), 32'h0);
        check("sw_early_we", 32'(r.early_we), 32'h0);
        if (log_q.size() == 2) begin
            check("sw_b0_we", 32'(log_q[0].we), 32'h1);
            check("sw_b0_addr", log_q[0].addr, 32'h300);
            check("sw_b0_be", 32'(log_q[0].be), 32'hC);
            check("sw_b0_wdata", log_q[0].wdata, 32'hCCDD0000);
            check("sw_b1_addr", log_q[1].addr, 32'h304);
            check("sw_b1_be", 32'(log_q[1].be), 32'h3);
            check("sw_b1_wdata", log_q[1].wdata, 32'h0000AABB);
        end

        // Split LH at 0x3FF with three wait cycles per beat.
        poke(32'h3FC, 32'h12345678);
        poke(32'h400, 32'h9ABCDEF0);
        fixed_wait = 3;
        run_op(MEM_LH, 32'h3FF, 32'h0, 32'h0, 5'd11, 1'b1, r);
        check("ws_stalls", r.stalls, 9);
        check("ws_beats", r.beats, 2);
        check("ws_wd", r.data, 32'hFFFFF012);
        check("ws_we", 32'(r.we), 32'h1);
        if (log_q.size() == 2) begin
            check("ws_b0_addr", log_q[0].addr, 32'h3FC);
            check("ws_b1_addr", log_q[1].addr, 32'h400);
            check("ws_b1_be", 32'(log_q[1].be), 32'h1);
        end

        // Reset while waiting in the second beat.
        fixed_wait = 5;
        @(negedge clk);
        log_q.delete();
        mem_op_i = MEM_LW; mem_addr_i = 32'h3FE; w_addr_i = 5'd8; w_enable_i = 1'b1;
        k = 0;
        while (log_q.size() < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reached_beat1", 32'(log_q.size()), 32'h1);
        #1;
        check("rstmid_req_before", 32'(mem_req_o), 32'h1);
        rst = 1'b1;
        mem_op_i = MEM_NOP; w_addr_i = 5'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_req_after", 32'(mem_req_o), 32'h0);
        check("rstmid_stall_after", 32'(stall_req_o), 32'h0);
        @(negedge clk);
        #1;
        check("rstmid_req_later", 32'(mem_req_o), 32'h0);
        check("rstmid_beats", 32'(log_q.size()), 32'h1);
        fixed_wait = 0;
        run_op(MEM_LW, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1, r);
        check("post_rst_lw", r.data, 32'hDEADBEEF);
        check("post_rst_stalls", r.stalls, 2);

        // Randomized ops against the byte model, random wait states.
        fixed_wait = -1;
        for (int n = 0; n < 300; n++) begin
            rv   = int'($urandom_range(0, 9));
            op   = (rv == 9) ? 4'hC : 4'(rv);
            addr = 32'($urandom_range(0, 32'hFF0));
            sd   = $urandom;
            wd   = $urandom;
            wa   = 5'($urandom_range(0, 31));
            we   = 1'($urandom);
            run_op(op, addr, sd, wd, wa, we, r);
            if (op_size(op) == 0) begin
                check("rnd_pass_we", 32'(r.we), 32'(we && wa != 0));
                check("rnd_pass_wd", r.data, (wa != 0) ? wd : 32'h0);
                check("rnd_pass_wa", 32'(r.waddr), 32'(wa));
                check("rnd_pass_stalls", r.stalls, 0);
            end else begin
                nb = ((int'(addr[1:0]) + op_size(op)) > 4) ? 2 : 1;
                check("rnd_beats", r.beats, nb);
                check("rnd_stalls_ok", 32'(r.stalls >= 1 + nb && r.stalls <= 1 + 3 * nb), 32'h1);
                check("rnd_early_we", 32'(r.early_we), 32'h0);
                if (op >= MEM_SB) begin
                    check("rnd_store_we", 32'(r.we), 32'h0);
                    model_store(op, addr, sd);
                end else begin
                    exp = model_load(op, addr);
                    check("rnd_load_we", 32'(r.we), 32'(we && wa != 0));
                    check("rnd_load_wd", r.data, (wa != 0) ? exp : 32'h0);
                end
            end
        end

        // Final memory image must match the byte model.
        bad_words = 0;
        for (int w = 0; w < 1024; w++) begin
            if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
                bad_words++;
        end
        check("mem_image_bad_words", bad_words, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of EX. It consumes the EX write-back triple plus a memory op, address and store data.
- Runs loads and stores over a word-wide req/ready memory port, splitting misaligned accesses that cross a word boundary into two aligned beats.
- Sign/zero-extends load data and asserts stall_req_o while a transaction is outstanding.
- Non-memory instructions pass through in zero extra cycles.

Parameters:
ADDR_W, 32, byte-address width of mem_addr_i and mem_addr_o (data path fixed at 32 bits)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
w_enable_i  input  1  write-back enable from EX
w_addr_i  input  5  destination register
w_data_i  input  32  EX result (passthrough for non-memory ops)
mem_op_i  input  4  memory op code (MEM_* package constants)
mem_addr_i  input  ADDR_W  effective byte address
mem_sdata_i  input  32  store data (rs2)
w_enable_o  output  1  write-back enable
w_addr_o  output  5  destination register
w_data_o  output  32  write-back data
stall_req_o  output  1  hold upstream pipeline
mem_req_o  output  1  memory request valid
mem_we_o  output  1  1 = write beat
mem_addr_o  output  ADDR_W  word-aligned address, bits[1:0] = 0
mem_be_o  output  4  byte enables
mem_wdata_o  output  32  write data, lane-aligned
mem_ready_i  input  1  beat accepted/completed; mem_rdata_i valid same cycle
mem_rdata_i  input  32  read data

Behaviour:
- Reset (sync) values: all outputs 0; state IDLE; beat-0 data register 0.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE, mem_op_i == MEM_NOP:
  - w_* outputs = inputs, combinationally; stall_req_o = 0.
  - If w_addr_i == 0, force w_enable_o = 0 and w_data_o = 0.
- IDLE, mem_op_i != NOP:
  - stall_req_o = 1 combinationally this cycle; next state BEAT0.
  - w_enable_o = 0 until DONE.
- Size: B = 1, H = 2, W = 4 bytes; off = mem_addr_i[1:0].
- split = (off + size > 4). Only LH/SH with off = 3, or LW/SW with off != 0.
- mask8 = ((1<<size)-1) << off.
- BEAT0:
  - mem_addr_o = {mem_addr_i[ADDR_W-1:2], 2'b00}; mem_be_o = mask8[3:0].
  - mem_wdata_o = (sdata << 8*off)[31:0].
- BEAT1:
  - mem_addr_o = BEAT0 address + 4, wrapping modulo 2^ADDR_W; mem_be_o = mask8[7:4].
  - mem_wdata_o = (sdata << 8*off)[63:32].
- Handshake:
  - mem_req_o = 1 in BEAT0/BEAT1.
  - mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o hold stable until a rising edge with mem_ready_i = 1.
  - A beat completes at that edge; there is no timeout.
  - mem_ready_i is ignored outside BEAT0/BEAT1.
- Transitions:
  - BEAT0 + ready: go to BEAT1 if split, else DONE. Capture mem_rdata_i into the beat-0 register.
  - BEAT1 + ready: go to DONE. Capture mem_rdata_i into the beat-1 register.
  - Minimum latency: 1 stall cycle (IDLE) + 1 per beat. Zero-wait single beat = 2 stall cycles, DONE on the 3rd.
- DONE (exactly 1 cycle):
  - stall_req_o = 0, so upstream advances; mem_req_o = 0; next state IDLE.
  - Loads: raw = ({beat1, beat0} >> 8*off)[31:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW takes raw.
  - Loads: w_enable_o = w_enable_i && w_addr_i != 0; w_data_o = extended value, or 0 if w_addr_i == 0.
  - Stores: w_enable_o = 0.
  - Inputs are held stable by the stall through DONE.
- Loads to x0 still perform the bus access; only write-back is suppressed.
- Undefined mem_op codes are treated as MEM_NOP.
- rst asserted mid-transaction: next cycle state IDLE and mem_req_o = 0; the transaction is abandoned and the memory side must tolerate a dropped request.

Decomposition:
- Shared package / Defines.vh:
  - MEM_NOP=0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
  - MemOpBus width 4; state encodings.
  - Reuse existing RegBus, RegAddrBus, ZeroWord, WriteDisable.
- One combinational sub-module, mem_align: from op, offset and store data it produces mask8, the split flag and the shifted 64-bit store data, and it extracts/extends load data. The FSM stays in mem_stage.

Test Plan:
- ALU passthrough: NOP, w_addr_i=5, w_data_i=0x1234 → same cycle w_enable_o=1, w_data_o=0x1234, stall_req_o=0, mem_req_o=0.
- Aligned LW:
  - Stimulus: addr=0x100, rdata=0xDEADBEEF, ready on first beat cycle.
  - Response: addr_o=0x100, be=4'hF; stall 2 cycles, then DONE with w_data_o=0xDEADBEEF.
- LB sign-extend:
  - Stimulus: addr=0x203, rdata=0x80000000.
  - Response: be=4'h8, w_data_o=0xFFFFFF80; the same access as LBU gives 0x00000080.
- Split SW:
  - Stimulus: addr=0x302, sdata=0xAABBCCDD.
  - Beat0: addr 0x300, be=4'hC, wdata=0xCCDD0000. Beat1: addr 0x304, be=4'h3, wdata=0x0000AABB. w_enable_o stays 0.
- Wait states: ready held low 3 cycles on LH addr=0x3FF (split) → request signals stable throughout; BEAT1 addr=0x400; result equals bytes {0x400[7:0], 0x3FC[31:24]} sign-extended.
- Reset in BEAT1, and load to x0: rst pulse → mem_req_o=0, stall_req_o=0 next cycle; LW to x0 → bus beat issued, w_enable_o=0 in DONE.
